// File: rtl/even_parity_enc_fifo_if.sv
`default_nettype none
//============================================================================
// Module   : even_parity_enc_fifo_if
// Purpose  : Handshake bundle for even_parity_enc_fifo. Carries the write
//            side (in_valid/in_ready/in_data), the read side
//            (out_valid/out_ready/out_data) and the occupancy count.
// Modports : master - producer/consumer side (drives in_*, out_ready)
//            slave  - FIFO side (drives in_ready, out_valid, out_data, count)
// Revision : 1.0 - initial release
//============================================================================
interface even_parity_enc_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W:0]          out_data;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output count
    );
endinterface
`default_nettype wire

// File: rtl/even_parity_enc_fifo.sv
`default_nettype none
//============================================================================
// Module   : even_parity_enc_fifo
// Purpose  : Appends an even parity bit to each DATA_W-bit word accepted on a
//            valid/ready input and buffers the DATA_W+1-bit result in a
//            DEPTH-entry FIFO presented on a valid/ready output. Every word
//            emitted has XOR of all bits equal to 0; out_data is held at 0
//            while empty so a downstream parity checker never sees odd data.
// Ports    : clk      - single clock, rising edge
//            reset    - asynchronous assert, active-low
//            bus      - even_parity_enc_fifo_if.slave
//                       in_valid/in_ready/in_data   : write handshake
//                       out_valid/out_ready/out_data: read handshake,
//                                                     out_data = {parity, data}
//                       count                       : occupancy 0..DEPTH
//            err_inj  - (only with EVEN_PARITY_ENC_ERR_INJ_EN) inverts the
//                       stored parity bit of the word pushed on this cycle
// Params   : DATA_W >= 1, DEPTH power of 2 and >= 2
// Macro    : EVEN_PARITY_ENC_ERR_INJ_EN enables the err_inj port
// Revision : 1.0 - initial release
//============================================================================
module even_parity_enc_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    even_parity_enc_fifo_if.slave bus
`ifdef EVEN_PARITY_ENC_ERR_INJ_EN
    ,
    input  wire logic             err_inj
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [DATA_W:0]      r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_parity;
    logic [DATA_W:0]      w_entry;

    // Flags come only from registered occupancy, so there is no
    // combinational path from in_valid/out_ready to in_ready/out_valid.
    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid  && !w_full;
    assign w_pop   = bus.out_ready && !w_empty;

`ifdef EVEN_PARITY_ENC_ERR_INJ_EN
    // Inverting the parity bit makes this one word odd on purpose.
    assign w_parity = (^bus.in_data) ^ err_inj;
`else
    assign w_parity = ^bus.in_data;
`endif
    assign w_entry = {w_parity, bus.in_data};

    // Storage carries no reset: contents are meaningless until written and
    // are never observed while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so wrap is free.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty;
    assign bus.count     = r_count;
    // Zero while empty: also covers reset, since r_count clears asynchronously.
    assign bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_even_parity_enc_fifo.sv
`default_nettype none
//============================================================================
// Module   : tb_even_parity_enc_fifo
// Purpose  : Self-checking bench for even_parity_enc_fifo. A driver issues
//            directed and random traffic, tracks expected occupancy and
//            pushes expected encoded words into a scoreboard queue; a
//            monitor pops and compares whenever the DUT completes an output
//            handshake.
// Revision : 1.0 - initial release
//============================================================================
module tb_even_parity_enc_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef EVEN_PARITY_ENC_ERR_INJ_EN
    logic err_inj = 1'b0;
`endif

    always #5 clk = ~clk;

    even_parity_enc_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    even_parity_enc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (rst_n),
        .bus     (bus.slave)
`ifdef EVEN_PARITY_ENC_ERR_INJ_EN
        ,
        .err_inj (err_inj)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int mcount = 0;                 // expected occupancy after the last edge
    logic [DATA_W:0] sb_q[$];       // expected words in output order

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding: the payload with a bit on top making the
    // population count even (odd when injecting an error).
    function automatic logic [DATA_W:0] encode(input logic [DATA_W-1:0] d, input logic inj);
        int ones = 0;
        for (int i = 0; i < DATA_W; i++) ones += d[i];
        return {((ones % 2) == 1) ^ inj, d};
    endfunction

    // One clock of stimulus: check the state left by the previous edge,
    // then present inputs for the next edge and update the expectation.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic e);
        bit acc;
        bit pop;
        @(posedge clk);
        #2;
        chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, mcount != DEPTH});
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mcount != 0});
        chk("count",     32'(bus.count),         32'(mcount));
        if (mcount == 0) chk("idle_out_data", 32'(bus.out_data), 32'd0);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
`ifdef EVEN_PARITY_ENC_ERR_INJ_EN
        err_inj = e;
`endif
        acc = v && (mcount != DEPTH);
        pop = r && (mcount != 0);
        if (acc) sb_q.push_back(encode(d, e));
        mcount = mcount + int'(acc) - int'(pop);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && mcount != 0; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data",  32'(bus.out_data),      32'd0);
        chk("rst_count",     32'(bus.count),         32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        sb_q.delete();
        mcount = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: compares every completed output handshake with the
    // scoreboard, and checks that a stalled head word does not change.
    logic            prev_hold = 1'b0;
    logic [DATA_W:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && bus.out_valid)
                chk("stall_stable", 32'(bus.out_data), 32'(prev_data));
`ifndef EVEN_PARITY_ENC_ERR_INJ_EN
            if (^bus.out_data !== 1'b0)
                chk("parity_even", {31'd0, ^bus.out_data}, 32'd0);
`endif
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pop", 32'(bus.out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("out_data", 32'(bus.out_data), 32'(sb_q.pop_front()));
                end
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
        end
    end

    initial begin
        logic [DATA_W-1:0] words [4];
        words[0] = 8'h00; words[1] = 8'h01; words[2] = 8'h03; words[3] = 8'h80;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        do_reset();
        repeat (5) step(1'b0, '0, 1'b0, 1'b0);

        // Back-to-back fill, then drain in order.
        for (int i = 0; i < 4; i++) step(1'b1, words[i], 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        drain();

        // Full: held push of FF is ignored until a pop frees a slot.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        repeat (3) step(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b1, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        drain();

        // Streaming at occupancy 1 across several pointer wraps.
        step(1'b1, 8'h0F, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, DATA_W'(8'h10 + i), 1'b1, 1'b0);
        drain();

        // Reset with three words buffered, then a fresh word.
        for (int i = 0; i < 3; i++) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 8'h07, 1'b0, 1'b0);
        drain();

`ifdef EVEN_PARITY_ENC_ERR_INJ_EN
        step(1'b1, 8'h05, 1'b0, 1'b1);
        step(1'b1, 8'h05, 1'b0, 1'b0);
        drain();
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, DATA_W'($urandom), $urandom % 2 == 1,
`ifdef EVEN_PARITY_ENC_ERR_INJ_EN
                 ($urandom % 8) == 0
`else
                 1'b0
`endif
            );
        end
        drain();
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
